// File: rtl/led_ring_if.sv
// led_ring_if: step/auto/load controls and ring outputs; master drives controls, slave is the sequencer
interface led_ring_if;
  logic step_valid;
  logic step_dir;
  logic step_ready;
  logic auto_en;
  logic auto_dir;
  logic load_valid;
  logic [2:0] load_pos;
  logic [2:0] pos;
  logic [11:0] led;
  logic step_done;
  logic busy;
  modport master (
    output step_valid, step_dir, auto_en, auto_dir, load_valid, load_pos,
    input  step_ready, pos, led, step_done, busy
  );
  modport slave (
    input  step_valid, step_dir, auto_en, auto_dir, load_valid, load_pos,
    output step_ready, pos, led, step_done, busy
  );
endinterface

// File: rtl/led_ring_sequencer.sv
// led_ring_sequencer: 8-position LED ring controller (load/step/auto moves, dwell, 3x4 LED decode; clk, rst, bus slave; load path under LED_SEQ_LOAD_EN)
module led_ring_sequencer #(
  parameter int DWELL = 2,
  parameter int AUTO_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  led_ring_if.slave bus
);
  typedef enum logic {IDLE, DWELL_ST} state_t;
  state_t state, state_n;
  logic [2:0] pos, pos_n, load_pos_i;
  logic [7:0] cnt, cnt_n;
  logic [15:0] auto_cnt, auto_cnt_n;
  logic auto_pend, auto_pend_n;
  logic step_done;
  logic load_act, step_ready, step_acc, auto_mv, tick, move;
`ifdef LED_SEQ_LOAD_EN
  assign load_act = bus.load_valid;
  assign load_pos_i = bus.load_pos;
`else
  logic unused_load;
  assign load_act = 1'b0;
  assign load_pos_i = 3'd0;
  assign unused_load = ^{bus.load_valid, bus.load_pos};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos <= 3'd0;
      cnt <= 8'd0;
      auto_cnt <= 16'd0;
      auto_pend <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      cnt <= cnt_n;
      auto_cnt <= auto_cnt_n;
      auto_pend <= auto_pend_n;
      step_done <= move;
    end
  end
  always_comb begin
    step_acc = bus.step_valid && step_ready;
    auto_mv = state == IDLE && !load_act && !step_acc && auto_pend;
    move = load_act || step_acc || auto_mv;
    tick = bus.auto_en && auto_cnt == 16'(AUTO_PERIOD - 1);
    pos_n = load_act ? load_pos_i :
            step_acc ? pos + (bus.step_dir ? 3'd1 : 3'd7) :
            auto_mv  ? pos + (bus.auto_dir ? 3'd1 : 3'd7) : pos;
    state_n = move ? DWELL_ST : (state == DWELL_ST && cnt == 8'd0) ? IDLE : state;
    cnt_n = move ? 8'(DWELL - 1) : (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    auto_cnt_n = !bus.auto_en ? 16'd0 : tick ? 16'd0 : auto_cnt + 16'd1;
    // a tick landing while a tick is already pending is dropped, so consumption wins
    auto_pend_n = !bus.auto_en ? 1'b0 : (load_act || auto_mv) ? 1'b0 : tick ? 1'b1 : auto_pend;
  end
  always_comb begin
    step_ready = state == IDLE && !load_act;
    bus.step_ready = step_ready;
    bus.busy = state == DWELL_ST;
    bus.pos = pos;
    bus.step_done = step_done;
    // lower half lights rows 0-1 at column pos, upper half rows 1-2 at column 7-pos
    bus.led = pos[2] ? 12'h110 << (3'd7 - pos) : 12'h011 << pos;
  end
endmodule
